// File: rtl/ooo_frontend_pkg.sv
// Shared front-end types and constants for the return-address-stack checkpoint queue.
package ooo_frontend_pkg;

  localparam int RAS_ADDRESS  = 3;
  localparam int XLEN         = 32;
  localparam int CKPT_ADDRESS = 3;
  localparam int CKPT_DEPTH   = 1 << CKPT_ADDRESS;

  // One checkpoint: stack pointer plus the top two stack entries ([XLEN-1:0] is top of stack).
  typedef struct packed {
    logic [RAS_ADDRESS-1:0] sp;
    logic [2*XLEN-1:0]      ras;
  } ras_ckpt_t;

  // Distance of a tag from the oldest live entry; the index width wraps modulo CKPT_DEPTH.
  function automatic logic [CKPT_ADDRESS-1:0] ckpt_age(input logic [CKPT_ADDRESS-1:0] tag,
                                                       input logic [CKPT_ADDRESS-1:0] head);
    return tag - head;
  endfunction

endpackage

// File: rtl/ras_checkpoint_buffer_if.sv
// Allocation, commit, mispredict and restore signals between the front end and the checkpoint queue.
interface ras_checkpoint_buffer_if;
  import ooo_frontend_pkg::*;

  logic                    alloc_valid;
  logic [RAS_ADDRESS-1:0]  sp_snap;
  logic [2*XLEN-1:0]       ras_snap;
  logic                    alloc_ready;
  logic [CKPT_ADDRESS-1:0] alloc_tag;
  logic                    commit_valid;
  logic                    mispredict_valid;
  logic [CKPT_ADDRESS-1:0] mispredict_tag;
  logic                    restore_ras;
  logic [RAS_ADDRESS-1:0]  rb_sp_snap;
  logic [2*XLEN-1:0]       rb_ras_snap;
  logic [CKPT_ADDRESS:0]   count;
  logic                    full;
  logic                    empty;

  modport master (
    output alloc_valid, sp_snap, ras_snap, commit_valid, mispredict_valid, mispredict_tag,
    input  alloc_ready, alloc_tag, restore_ras, rb_sp_snap, rb_ras_snap, count, full, empty
  );

  modport slave (
    input  alloc_valid, sp_snap, ras_snap, commit_valid, mispredict_valid, mispredict_tag,
    output alloc_ready, alloc_tag, restore_ras, rb_sp_snap, rb_ras_snap, count, full, empty
  );

endinterface

// File: rtl/ras_checkpoint_buffer_ckpt_ptr_ctrl.sv
// Head/tail pointers with wrap bit, occupancy flags and mispredict liveness for the checkpoint queue.
module ckpt_ptr_ctrl
  import ooo_frontend_pkg::*;
(
  input  logic                    CLK,
  input  logic                    reset,
  input  logic                    alloc_valid,
  input  logic                    commit_valid,
  input  logic                    mispredict_valid,
  input  logic [CKPT_ADDRESS-1:0] mispredict_tag,
  output logic                    alloc_ready,
  output logic                    mispredict_fire,
  output logic [CKPT_ADDRESS-1:0] tail_idx,
  output logic [CKPT_ADDRESS:0]   count,
  output logic                    full,
  output logic                    empty
);

  localparam int PW = CKPT_ADDRESS + 1;

  logic [PW-1:0]           head, tail, head_nxt, tail_nxt;
  logic [CKPT_ADDRESS-1:0] age;
  logic                    commit_en;

  assign tail_idx = tail[CKPT_ADDRESS-1:0];

  // Flags, liveness and next pointers, all judged on the pre-edge pointers.
  always_comb begin
    count           = tail - head;
    empty           = (head == tail);
    full            = (head[CKPT_ADDRESS-1:0] == tail[CKPT_ADDRESS-1:0]) &&
                      (head[CKPT_ADDRESS] != tail[CKPT_ADDRESS]);
    age             = ckpt_age(mispredict_tag, head[CKPT_ADDRESS-1:0]);
    mispredict_fire = mispredict_valid && ({1'b0, age} < count);
    alloc_ready     = alloc_valid && !full && !mispredict_valid;
    commit_en       = commit_valid && !empty;
    head_nxt        = head + PW'(commit_en);
    tail_nxt        = tail;
    // Keep the mispredicted branch's own entry; tail is rebuilt from the old head.
    if (mispredict_fire)
      tail_nxt = head + {1'b0, age} + PW'(1);
    else if (alloc_ready)
      tail_nxt = tail + PW'(1);
  end

  // Pointer registers.
  always_ff @(posedge CLK) begin
    if (reset) begin
      head <= '0;
      tail <= '0;
    end else begin
      head <= head_nxt;
      tail <= tail_nxt;
    end
  end

endmodule

// File: rtl/ras_checkpoint_buffer.sv
// Circular checkpoint queue: captures RAS snapshots per control-flow op and replays one on mispredict.
module ras_checkpoint_buffer
  import ooo_frontend_pkg::*;
(
  input logic                    CLK,
  input logic                    reset,
  ras_checkpoint_buffer_if.slave bus
);

  ras_ckpt_t              mem [CKPT_DEPTH];
  ras_ckpt_t              rd_entry;
  logic                   alloc_ready;
  logic                   mispredict_fire;
  logic [CKPT_ADDRESS-1:0] tail_idx;
  logic                   restore_q;
  logic [RAS_ADDRESS-1:0] rb_sp_q;
  logic [2*XLEN-1:0]      rb_ras_q;

  ckpt_ptr_ctrl u_ptr (
    .CLK              (CLK),
    .reset            (reset),
    .alloc_valid      (bus.alloc_valid),
    .commit_valid     (bus.commit_valid),
    .mispredict_valid (bus.mispredict_valid),
    .mispredict_tag   (bus.mispredict_tag),
    .alloc_ready      (alloc_ready),
    .mispredict_fire  (mispredict_fire),
    .tail_idx         (tail_idx),
    .count            (bus.count),
    .full             (bus.full),
    .empty            (bus.empty)
  );

  assign bus.alloc_ready = alloc_ready;
  assign bus.alloc_tag   = tail_idx;
  assign bus.restore_ras = restore_q;
  assign bus.rb_sp_snap  = rb_sp_q;
  assign bus.rb_ras_snap = rb_ras_q;

  // Asynchronous read of the mispredicted entry; alloc is blocked that cycle so no write collides.
  assign rd_entry = mem[bus.mispredict_tag];

  // Single write port: capture the snapshot into the tail slot on accepted allocation.
  always_ff @(posedge CLK) begin
    if (alloc_ready)
      mem[tail_idx] <= '{sp: bus.sp_snap, ras: bus.ras_snap};
  end

  // Restore pulse and held rollback values; reset also cancels a pending pulse.
  always_ff @(posedge CLK) begin
    if (reset) begin
      restore_q <= 1'b0;
      rb_sp_q   <= '0;
      rb_ras_q  <= '0;
    end else begin
      restore_q <= mispredict_fire;
      if (mispredict_fire) begin
        rb_sp_q  <= rd_entry.sp;
        rb_ras_q <= rd_entry.ras;
      end
    end
  end

endmodule

// File: tb/tb_ras_checkpoint_buffer.sv
// Directed plus randomized check of ras_checkpoint_buffer against a queue-based reference model.
module tb_ras_checkpoint_buffer;
  import ooo_frontend_pkg::*;

  typedef struct {
    logic [2:0]  sp;
    logic [63:0] ras;
  } ent_t;

  logic CLK = 1'b0;
  logic reset;
  ras_checkpoint_buffer_if bus();

  ras_checkpoint_buffer dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  // Model: the live checkpoints in age order, and the tag of the oldest one.
  ent_t        q[$];
  int          head_tag;
  bit          exp_restore;
  logic [2:0]  exp_rb_sp;
  logic [63:0] exp_rb_ras;

  localparam logic [31:0] A = 32'hA0A0_0001, B = 32'hB0B0_0002, C = 32'hC0C0_0003;
  localparam logic [31:0] D = 32'hD0D0_0004, E = 32'hE0E0_0005, F = 32'hF0F0_0006;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    head_tag    = 0;
    exp_restore = 0;
    exp_rb_sp   = '0;
    exp_rb_ras  = '0;
  endtask

  // Drive one cycle, check outputs against the model before the edge, then advance the model.
  task automatic cyc(input bit av, input logic [2:0] sp, input logic [63:0] ras,
                     input bit cv, input bit mv, input logic [2:0] mt, input bit rst);
    int sz, age;
    bit acc, live;
    bus.alloc_valid      = av;
    bus.sp_snap          = sp;
    bus.ras_snap         = ras;
    bus.commit_valid     = cv;
    bus.mispredict_valid = mv;
    bus.mispredict_tag   = mt;
    reset                = rst;
    sz   = q.size();
    age  = (int'(mt) - head_tag) & 7;
    live = age < sz;
    acc  = av && (sz < 8) && !mv;
    @(negedge CLK);
    chk("alloc_ready", 64'(bus.alloc_ready), 64'(acc));
    chk("alloc_tag",   64'(bus.alloc_tag),   64'((head_tag + sz) % 8));
    chk("count",       64'(bus.count),       64'(sz));
    chk("full",        64'(bus.full),        64'(sz == 8));
    chk("empty",       64'(bus.empty),       64'(sz == 0));
    chk("restore_ras", 64'(bus.restore_ras), 64'(exp_restore));
    chk("rb_sp_snap",  64'(bus.rb_sp_snap),  64'(exp_rb_sp));
    chk("rb_ras_snap", bus.rb_ras_snap,      exp_rb_ras);
    if (rst) begin
      model_reset();
    end else begin
      exp_restore = 0;
      if (mv && live) begin
        exp_restore = 1;
        exp_rb_sp   = q[age].sp;
        exp_rb_ras  = q[age].ras;
        while (q.size() > age + 1) void'(q.pop_back());
      end
      if (cv && q.size() > 0) begin
        void'(q.pop_front());
        head_tag = (head_tag + 1) % 8;
      end
      if (acc) q.push_back('{sp: sp, ras: ras});
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic alloc(input logic [2:0] sp, input logic [63:0] ras);
    cyc(1, sp, ras, 0, 0, 3'd0, 0);
  endtask

  task automatic idle();
    cyc(0, 3'd0, 64'd0, 0, 0, 3'd0, 0);
  endtask

  task automatic do_reset();
    cyc(0, 3'd0, 64'd0, 0, 0, 3'd0, 1);
  endtask

  initial begin
    bus.alloc_valid = 0; bus.sp_snap = 0; bus.ras_snap = 0;
    bus.commit_valid = 0; bus.mispredict_valid = 0; bus.mispredict_tag = 0;
    reset = 1;
    repeat (2) @(posedge CLK);
    #1;
    model_reset();

    // Reset state and first allocations.
    idle();
    chk("reset_empty", 64'(bus.empty), 64'd1);
    chk("reset_tag",   64'(bus.alloc_tag), 64'd0);
    alloc(3'd1, {A, B});
    alloc(3'd2, {C, D});
    alloc(3'd3, {E, F});
    chk("three_count", 64'(bus.count), 64'd3);
    idle();

    // Fill, refused 9th alloc with commit, then wrap to tag 0.
    do_reset();
    for (int i = 0; i < 8; i++) alloc(3'(i), {32'(i), 32'(i + 100)});
    chk("fill_full", 64'(bus.full), 64'd1);
    cyc(1, 3'd7, 64'h99, 1, 0, 3'd0, 0);
    chk("wrap_tag", 64'(bus.alloc_tag), 64'd0);
    alloc(3'd7, 64'h99);
    chk("wrap_count", 64'(bus.count), 64'd8);
    idle();

    // Mispredict tag 1 with four live entries.
    do_reset();
    alloc(3'd1, {A, B});
    alloc(3'd2, {C, D});
    alloc(3'd3, {E, F});
    alloc(3'd4, 64'h1234);
    cyc(0, 3'd0, 64'd0, 0, 1, 3'd1, 0);
    chk("mp1_rb_sp", 64'(bus.rb_sp_snap), 64'd2);
    idle();
    idle();

    // Dead tag ignored, then drain and commit while empty.
    do_reset();
    alloc(3'd1, {A, B});
    alloc(3'd2, {C, D});
    alloc(3'd3, {E, F});
    cyc(0, 3'd0, 64'd0, 0, 1, 3'd5, 0);
    for (int i = 0; i < 4; i++) cyc(0, 3'd0, 64'd0, 1, 0, 3'd0, 0);
    idle();

    // Mispredict on the committing entry with a competing alloc.
    do_reset();
    alloc(3'd5, {A, B});
    alloc(3'd6, {C, D});
    cyc(1, 3'd7, {E, F}, 1, 1, 3'd0, 0);
    idle();

    // Mispredict followed by reset cancels the pulse.
    alloc(3'd1, {A, B});
    cyc(0, 3'd0, 64'd0, 0, 1, 3'd0, 0);
    do_reset();
    idle();
    chk("post_reset_tag", 64'(bus.alloc_tag), 64'd0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 9) < 6,
          3'($urandom),
          {$urandom, $urandom},
          $urandom_range(0, 9) < 3,
          $urandom_range(0, 9) < 1,
          3'($urandom),
          $urandom_range(0, 199) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ras_checkpoint_buffer.md
Name: ras_checkpoint_buffer

Overview:
- Circular checkpoint queue for return-address-stack recovery in the out-of-order front end.
- On each in-flight control-flow instruction it captures the stack pointer and top-two-entry snapshot that the return address stack publishes (sp_snap, ras_snap), and returns a checkpoint tag.
- On a branch mispredict it drives the stack's restore interface (restore_ras, rb_sp_snap, rb_ras_snap) and squashes younger checkpoints.
- Entries are freed in order at commit.

Parameters:
- RAS_ADDRESS, 3, stack-pointer width of the return address stack.
- XLEN, 32, address width.
- CKPT_ADDRESS, 3, checkpoint index width.
- CKPT_DEPTH, 1<<CKPT_ADDRESS, number of checkpoint entries.

Ports:
- CLK  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- alloc_valid  in  1  request to allocate a checkpoint this cycle.
- sp_snap  in  RAS_ADDRESS  stack-pointer snapshot to store.
- ras_snap  in  2*XLEN  top-two-entry snapshot to store; [XLEN-1:0] is top of stack.
- alloc_ready  out  1  allocation accepted this cycle.
- alloc_tag  out  CKPT_ADDRESS  tag of the entry written this cycle.
- commit_valid  in  1  free the oldest entry.
- mispredict_valid  in  1  recover to the checkpoint given by mispredict_tag.
- mispredict_tag  in  CKPT_ADDRESS  tag of the mispredicted branch.
- restore_ras  out  1  one-cycle restore pulse to the return address stack.
- rb_sp_snap  out  RAS_ADDRESS  restored stack pointer.
- rb_ras_snap  out  2*XLEN  restored top-two entries.
- count  out  CKPT_ADDRESS+1  number of live entries.
- full  out  1  count == CKPT_DEPTH.
- empty  out  1  count == 0.

Behaviour:
- Clock and reset: CLK, with reset synchronous and active-high.
- Storage and pointers:
  - Storage is CKPT_DEPTH entries of {sp, ras}.
  - Pointers head and tail are each CKPT_ADDRESS+1 bits, where the MSB is the wrap bit.
  - count = tail - head (modulo 2^(CKPT_ADDRESS+1)).
  - full when the indices are equal and the wrap bits differ; empty when head == tail.
- Reset:
  - head = tail = 0.
  - restore_ras = 0, rb_sp_snap = 0, rb_ras_snap = 0.
  - count = 0, empty = 1, full = 0.
  - Entry contents are don't-care.
- Allocation:
  - alloc_ready = alloc_valid & ~full & ~mispredict_valid. This is combinational.
  - alloc_tag = tail[CKPT_ADDRESS-1:0]. This is combinational and always driven.
  - When alloc_ready is high, entry[tail] <= {sp_snap, ras_snap} and tail increments at the clock edge.
  - A request made while full or while mispredict_valid is high is dropped. The requester must hold it and retry.
- Commit:
  - When commit_valid is high and the buffer is not empty, head increments.
  - commit_valid while empty is ignored.
- Mispredict:
  - Live check: mispredict_tag is live when (mispredict_tag - head index) mod CKPT_DEPTH < count.
  - Non-live tags are ignored: no pulse is issued and no pointer changes.
  - For a live tag, at the next edge: restore_ras <= 1, rb_sp_snap <= entry[tag].sp, rb_ras_snap <= entry[tag].ras.
  - Also at that edge, tail <= head + ((tag - head) mod CKPT_DEPTH) + 1. This keeps the mispredicted branch's own entry and squashes all younger entries.
  - Latency is 1 cycle from mispredict_valid to restore_ras.
- Restore outputs:
  - restore_ras is high for exactly one cycle per accepted mispredict.
  - rb_sp_snap and rb_ras_snap hold their last value when restore_ras is low.
- Simultaneous events:
  - Mispredict with commit: both apply. Head increments, and tail is computed from the pre-increment head. If the committing entry is the mispredict tag, the restore still issues and the buffer ends empty.
  - Mispredict with alloc: alloc is refused because alloc_ready = 0.
  - Commit with alloc while full: alloc is refused because full is evaluated on the pre-edge state. Alloc is accepted the next cycle.
- Back-to-back mispredicts: each cycle is handled independently against the state updated by the previous cycle, and each produces its own restore pulse. The checkpoint is taken before any return pop of the branch is applied.
- Reset mid-operation: all pointers clear, and a pending restore pulse is cancelled (restore_ras = 0 on the cycle after reset).

Decomposition:
- Shared package (ooo_frontend_pkg):
  - typedef ras_ckpt_t = struct {logic [RAS_ADDRESS-1:0] sp; logic [2*XLEN-1:0] ras;}.
  - Constants RAS_ADDRESS, XLEN and CKPT_ADDRESS.
  - Function ckpt_age(tag, head) returning (tag - head) mod CKPT_DEPTH.
- One sub-module, ckpt_ptr_ctrl: holds the head/tail/wrap logic and the count/full/empty/live computation.
- The storage array and the restore output register stay in the top module. The array is distributed RAM with one write port and one asynchronous read port.

Test Plan:
- Reset, then 3 allocs with sp_snap=1,2,3 and ras_snap={A,B},{C,D},{E,F} -> alloc_tag 0,1,2; count=3; empty=0.
- Fill: 8 consecutive allocs -> full=1, count=8; 9th alloc -> alloc_ready=0; same cycle plus commit -> next-cycle alloc accepted with tag 0 (wrap); count stays 8.
- Mispredict tag=1 with 4 live (tags 0-3) -> next cycle restore_ras=1 for one cycle, rb_sp_snap=2, rb_ras_snap={C,D}; count=2; next alloc_tag=2.
- Mispredict tag=5 with head=0, count=3 (not live) -> no restore pulse, count unchanged; commit on empty -> count stays 0.
- Mispredict tag=0 with alloc_valid and commit_valid in the same cycle, head=0, count=2 -> alloc_ready=0, restore pulse carries entry 0, buffer empty afterward.
- Mispredict asserted, reset asserted the next cycle -> restore_ras=0 after reset, count=0, alloc_tag=0.
